demux32_8: RTL
==============

DEMUX32_8 -- requirements
Module: demux32_8

Interface
REQ-001 The block SHALL have the port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port data_in, input, 32 bits: word to serialize.
REQ-004 The block SHALL have the port valid_in, input, 1 bit: data_in carries a valid word.
REQ-005 The block SHALL have the port ready_out, output, 1 bit: the block can accept a word this cycle.
REQ-006 The block SHALL have the port data_out, output, 8 bits: serialized byte.
REQ-007 The block SHALL have the port valid_out, output, 1 bit: data_out carries a valid byte.
REQ-008 Only one clock SHALL be used; reset SHALL be synchronous and active-high.

Function
REQ-009 A word SHALL be accepted at a rising edge where valid_in=1 and ready_out=1; valid_in with ready_out=0 SHALL be ignored, with no state change.
REQ-010 The block SHALL have storage for one active word, one pending word (pending_valid flag) and a 2-bit byte counter cnt (0..3).
REQ-011 The FSM SHALL have two states, IDLE (nothing to send) and SEND (active word being emitted).
REQ-012 ready_out SHALL be combinational: ready_out = !pending_valid && !reset.
REQ-013 In IDLE, an accepted word SHALL load the active register, set cnt=0 and move to SEND; the byte with index 0 SHALL appear registered on data_out with valid_out=1 in the cycle after the accepting edge (latency 1).
REQ-014 In SEND, each edge SHALL advance cnt by 1 and present the next byte; the 4 bytes of a word SHALL be emitted in 4 consecutive cycles.
REQ-015 In SEND with cnt<3, an accepted word SHALL go to the pending register and set pending_valid.
REQ-016 In SEND with cnt=3 (last byte displayed), at the next edge:
- if pending_valid=1: load pending into active, clear pending_valid, cnt=0, stay in SEND;
- else if a word is accepted that edge: load it directly into active, cnt=0, stay in SEND;
- else: go to IDLE, with valid_out=0 and data_out=8'h00.
REQ-017 When pending_valid=1 and cnt=3, the pending word SHALL take priority; the input SHALL NOT be accepted that edge (ready_out=0).
REQ-018 Back-to-back words SHALL stream without gaps: sustained throughput of 1 word per 4 clk_4f cycles.
REQ-019 Whenever valid_out=0, data_out SHALL be 8'h00.
REQ-020 Default byte order SHALL be MSB first: index 0 = data_in[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].

Reset
REQ-021 While reset=1 at an edge: state=IDLE, cnt=0, pending_valid=0, active/pending registers=0, data_out=8'h00, valid_out=0.
REQ-022 ready_out SHALL be 0 during any cycle with reset=1.
REQ-023 Reset asserted mid-word SHALL discard the active and pending words with no further bytes emitted; valid_out=0 from the cycle after the reset edge.

Configuration
REQ-024 Macro DEMUX_LSB_FIRST_EN, when defined, SHALL reverse the byte order: index 0 = data_in[7:0] … index 3 = data_in[31:24].
REQ-025 When DEMUX_LSB_FIRST_EN is undefined, MSB-first order (REQ-020) SHALL apply; timing and handshake SHALL be identical in both builds.

Verification
REQ-026 Single word: reset then release, one cycle valid_in=1 with data_in=32'hA1B2C3D4 -> valid_out=1 for 4 cycles with data_out A1,B2,C3,D4 starting 1 cycle after accept, then valid_out=0 and data_out=00.
REQ-027 Back-to-back: 32'h11223344 then 32'h55667788, each presented on the first edge ready_out allows -> 8 consecutive valid bytes 11,22,33,44,55,66,77,88 with no gap.
REQ-028 Backpressure: valid_in held 1 with 3 distinct words -> ready_out=0 while pending is full; no word lost or duplicated; 12 bytes emitted in order.
REQ-029 Reset mid-operation: reset asserted after 2 bytes of 32'hDEADBEEF with a pending word held -> valid_out=0 and no further bytes; after release, 32'h01020304 emits 01,02,03,04.
REQ-030 With DEMUX_LSB_FIRST_EN defined: 32'hA1B2C3D4 -> D4,C3,B2,A1 with the same cycle timing as REQ-026.

Source files
------------

// File: rtl/demux32_8.sv
// 32-bit to 8-bit serializer: one active word plus one pending word, four bytes per word.
// Define DEMUX_LSB_FIRST_EN to emit bytes least-significant first (default is MSB first).
module demux32_8 (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] active_q, active_d;
  logic [31:0] pending_q, pending_d;
  logic        pending_vld_q, pending_vld_d;
  logic        accept;
  logic [7:0]  cur_byte;

  assign ready_out = !pending_vld_q && !reset;
  assign accept    = valid_in && ready_out;

  always_comb begin
    cur_byte = 8'h00;
`ifdef DEMUX_LSB_FIRST_EN
    case (cnt_q)
      2'd0:    cur_byte = active_q[7:0];
      2'd1:    cur_byte = active_q[15:8];
      2'd2:    cur_byte = active_q[23:16];
      default: cur_byte = active_q[31:24];
    endcase
`else
    case (cnt_q)
      2'd0:    cur_byte = active_q[31:24];
      2'd1:    cur_byte = active_q[23:16];
      2'd2:    cur_byte = active_q[15:8];
      default: cur_byte = active_q[7:0];
    endcase
`endif
  end

  // Outputs decode straight from flops; SEND always means byte cnt_q is on the wire.
  assign valid_out = (state_q == SEND);
  assign data_out  = valid_out ? cur_byte : 8'h00;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_d      = active_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    if (state_q == IDLE) begin
      if (accept) begin
        active_d = data_in;
        cnt_d    = 2'd0;
        state_d  = SEND;
      end
    end else if (cnt_q != 2'd3) begin
      cnt_d = cnt_q + 2'd1;
      if (accept) begin
        pending_d     = data_in;
        pending_vld_d = 1'b1;
      end
    end else begin
      // Last byte on the wire: pending word wins, then a fresh input, else go idle.
      cnt_d = 2'd0;
      if (pending_vld_q) begin
        active_d      = pending_q;
        pending_vld_d = 1'b0;
      end else if (accept) begin
        active_d = data_in;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      active_q      <= 32'h0;
      pending_q     <= 32'h0;
      pending_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
    end
  end

endmodule
